// File: rtl/cactus_collision_checker.sv
// Snapshots the cactus positions on each sync and scans them one per cycle against the dino box.
// Keeps a sticky game_over flag and a saturating score of the cactuses passed.
module cactus_collision_checker #(
    parameter int DINO_X   = 100,
    parameter int DINO_W   = 40,
    parameter int CACTUS_W = 20,
    parameter int CACTUS_H = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] cactus0,
    input  logic [11:0] cactus1,
    input  logic [11:0] cactus2,
    input  logic [11:0] cactus3,
    input  logic        cactus_sync,
    input  logic [9:0]  dino_y,
    input  logic        restart,
    output logic        game_over,
    output logic [1:0]  hit_index,
    output logic [15:0] score,
    output logic        scan_done,
    output logic        sync_overrun
);

    // state | meaning
    // IDLE  | waiting for a cactus_sync while the game is running
    // SCAN  | checking snap[idx] against the dino box, one cactus per cycle
    // DONE  | scan finished; scan_done is high for this one cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [12:0] DINO_LEFT   = 13'(DINO_X);
    localparam logic signed [12:0] DINO_RIGHT  = 13'(DINO_X + DINO_W - 1);
    localparam logic signed [12:0] CACTUS_SPAN = 13'(CACTUS_W - 1);
    localparam logic [10:0]        CACTUS_TOP  = 11'(CACTUS_H);

    state_t             state_q, state_d;
    logic [3:0][11:0]   snap_q, snap_d;
    logic [9:0]         snap_y_q, snap_y_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         pass_flag_q, pass_flag_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         hit_index_q, hit_index_d;
    logic [15:0]        score_q, score_d;
    logic               scan_done_q, scan_done_d;
    logic               sync_overrun_q, sync_overrun_d;

    logic [11:0]        cur_x;
    logic signed [12:0] x_s;
    logic signed [12:0] right_s;
    logic               overlap_x;
    logic               hit;
    logic               passed;

    // The x comparisons must be signed: cactuses re-enter from negative x after wrapping.
    assign cur_x     = snap_q[idx_q];
    assign x_s       = $signed({cur_x[11], cur_x});
    assign right_s   = x_s + CACTUS_SPAN;
    assign overlap_x = (x_s <= DINO_RIGHT) && (right_s >= DINO_LEFT);
    assign hit       = overlap_x && ({1'b0, snap_y_q} < CACTUS_TOP);
    assign passed    = x_s > DINO_RIGHT;

    always_comb begin
        state_d        = state_q;
        snap_d         = snap_q;
        snap_y_d       = snap_y_q;
        idx_d          = idx_q;
        pass_flag_d    = pass_flag_q;
        game_over_d    = game_over_q;
        hit_index_d    = hit_index_q;
        score_d        = score_q;
        scan_done_d    = 1'b0;
        sync_overrun_d = 1'b0;

        if (restart) begin
            state_d     = IDLE;
            idx_d       = 2'd0;
            pass_flag_d = 4'b0;
            game_over_d = 1'b0;
            hit_index_d = 2'd0;
            score_d     = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cactus_sync && !game_over_q) begin
                        snap_d   = {cactus3, cactus2, cactus1, cactus0};
                        snap_y_d = dino_y;
                        idx_d    = 2'd0;
                        state_d  = SCAN;
                    end
                end
                SCAN: begin
                    sync_overrun_d = cactus_sync;
                    // A flag only re-arms once the cactus is seen left of the dino again.
                    if (passed) begin
                        if (!pass_flag_q[idx_q]) begin
                            pass_flag_d[idx_q] = 1'b1;
                            if (score_q != 16'hFFFF) begin
                                score_d = score_q + 16'd1;
                            end
                        end
                    end else begin
                        pass_flag_d[idx_q] = 1'b0;
                    end

                    if (hit) begin
                        game_over_d = 1'b1;
                        hit_index_d = idx_q;
                        scan_done_d = 1'b1;
                        state_d     = DONE;
                    end else if (idx_q == 2'd3) begin
                        scan_done_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                DONE: begin
                    sync_overrun_d = cactus_sync;
                    state_d        = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            snap_q         <= '0;
            snap_y_q       <= 10'd0;
            idx_q          <= 2'd0;
            pass_flag_q    <= 4'b0;
            game_over_q    <= 1'b0;
            hit_index_q    <= 2'd0;
            score_q        <= 16'd0;
            scan_done_q    <= 1'b0;
            sync_overrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            snap_q         <= snap_d;
            snap_y_q       <= snap_y_d;
            idx_q          <= idx_d;
            pass_flag_q    <= pass_flag_d;
            game_over_q    <= game_over_d;
            hit_index_q    <= hit_index_d;
            score_q        <= score_d;
            scan_done_q    <= scan_done_d;
            sync_overrun_q <= sync_overrun_d;
        end
    end

    assign game_over    = game_over_q;
    assign hit_index    = hit_index_q;
    assign score        = score_q;
    assign scan_done    = scan_done_q;
    assign sync_overrun = sync_overrun_q;

endmodule

// File: tb/tb_cactus_collision_checker.sv
// Scoreboard bench for cactus_collision_checker: a behavioural model predicts each scan's
// latency, game_over, hit_index and score; the prediction is popped when scan_done pulses.
module tb_cactus_collision_checker;

    logic        clk;
    logic        reset_n;
    logic [11:0] cactus0, cactus1, cactus2, cactus3;
    logic        cactus_sync;
    logic [9:0]  dino_y;
    logic        restart;
    logic        game_over;
    logic [1:0]  hit_index;
    logic [15:0] score;
    logic        scan_done;
    logic        sync_overrun;

    cactus_collision_checker dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cactus0      (cactus0),
        .cactus1      (cactus1),
        .cactus2      (cactus2),
        .cactus3      (cactus3),
        .cactus_sync  (cactus_sync),
        .dino_y       (dino_y),
        .restart      (restart),
        .game_over    (game_over),
        .hit_index    (hit_index),
        .score        (score),
        .scan_done    (scan_done),
        .sync_overrun (sync_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lat;
        int go;
        int hi;
        int sc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    int   m_score = 0;
    int   m_go    = 0;
    int   m_hi    = 0;
    bit   m_pf[4] = '{0, 0, 0, 0};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_score = 0;
        m_go    = 0;
        m_hi    = 0;
        for (int k = 0; k < 4; k++) m_pf[k] = 1'b0;
    endtask

    // Dino box 100..139, cactus width 20, cactus height 40.
    function automatic exp_t model_scan(input int xs[4], input int y);
        exp_t e;
        e.lat = 4;
        for (int k = 0; k < 4; k++) begin
            if (xs[k] > 139) begin
                if (!m_pf[k]) begin
                    m_pf[k] = 1'b1;
                    if (m_score < 65535) m_score++;
                end
            end else begin
                m_pf[k] = 1'b0;
            end
            if (xs[k] <= 139 && xs[k] + 19 >= 100 && y < 40) begin
                m_go  = 1;
                m_hi  = k;
                e.lat = k + 1;
                break;
            end
        end
        e.go = m_go;
        e.hi = m_hi;
        e.sc = m_score;
        return e;
    endfunction

    // Runs one scan; ovr_at > 0 raises a second sync right after edge E0+ovr_at.
    task automatic do_scan(input int x0, input int x1, input int x2, input int x3,
                           input int y, input int ovr_at);
        int   xs[4];
        exp_t e;
        int   lat;
        xs = '{x0, x1, x2, x3};
        sb.push_back(model_scan(xs, y));
        @(posedge clk); #1;
        cactus0 = 12'(x0); cactus1 = 12'(x1); cactus2 = 12'(x2); cactus3 = 12'(x3);
        dino_y  = 10'(y);
        cactus_sync = 1'b1;
        @(posedge clk); #1;
        cactus_sync = 1'b0;
        cactus0 = 12'hFCE; cactus1 = 12'd100; cactus2 = 12'd100; cactus3 = 12'd100;
        dino_y = 10'd0;
        lat = 99;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (ovr_at > 0 && n == ovr_at) cactus_sync = 1'b1;
            if (ovr_at > 0 && n == ovr_at + 1) begin
                cactus_sync = 1'b0;
                check_val("overrun_pulse", sync_overrun, 1);
            end
            if (ovr_at > 0 && n == ovr_at + 2) check_val("overrun_clear", sync_overrun, 0);
            if (scan_done) begin
                lat = n;
                break;
            end
        end
        e = sb.pop_front();
        check_val("scan_latency", lat, e.lat);
        check_val("game_over", game_over, e.go);
        if (e.go != 0) check_val("hit_index", hit_index, e.hi);
        check_val("score", score, e.sc);
        @(posedge clk); #1;
        check_val("scan_done_width", scan_done, 0);
    endtask

    // A sync that must not start a scan (game over, or coincident restart).
    task automatic ignored_sync(input bit with_restart);
        bit seen_done;
        bit seen_ovr;
        seen_done = 0;
        seen_ovr  = 0;
        @(posedge clk); #1;
        cactus0 = 12'hFCE; cactus1 = 12'hFCE; cactus2 = 12'hFCE; cactus3 = 12'hFCE;
        cactus_sync = 1'b1;
        restart     = with_restart;
        @(posedge clk); #1;
        cactus_sync = 1'b0;
        restart     = 1'b0;
        if (with_restart) model_clear();
        for (int n = 0; n < 6; n++) begin
            if (scan_done) seen_done = 1;
            if (sync_overrun) seen_ovr = 1;
            @(posedge clk); #1;
        end
        check_val("ignored_no_scan", seen_done, 0);
        check_val("ignored_no_overrun", seen_ovr, 0);
        check_val("ignored_game_over", game_over, m_go);
        check_val("ignored_score", score, m_score);
    endtask

    task automatic do_restart();
        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        model_clear();
        check_val("restart_game_over", game_over, 0);
        check_val("restart_hit_index", hit_index, 0);
        check_val("restart_score", score, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        cactus0 = '0; cactus1 = '0; cactus2 = '0; cactus3 = '0;
        cactus_sync = 1'b0;
        dino_y  = '0;
        restart = 1'b0;
        #22;
        check_val("rst_game_over", game_over, 0);
        check_val("rst_hit_index", hit_index, 0);
        check_val("rst_score", score, 0);
        check_val("rst_scan_done", scan_done, 0);
        check_val("rst_overrun", sync_overrun, 0);
        reset_n = 1'b1;

        do_scan(-50, -50, -50, -50, 0, 0);
        do_scan(-50, 90, -50, -50, 0, 0);
        ignored_sync(1'b0);
        check_val("sticky_hit_index", hit_index, 1);

        do_restart();
        do_scan(-50, 90, -50, -50, 40, 0);
        do_scan(-50, 90, -50, -50, 39, 0);
        do_restart();

        for (int i = 0; i < 3; i++) do_scan(140, -50, -50, -50, 0, 0);
        do_scan(-50, -50, -50, -50, 0, 0);
        do_scan(140, -50, -50, -50, 0, 0);
        do_scan(-50, 160, 2047, -2048, 0, 0);

        do_scan(-50, -50, -50, -50, 0, 2);

        // Asynchronous reset in the middle of a scan.
        @(posedge clk); #1;
        cactus0 = 12'd140; cactus1 = 12'd140; cactus2 = 12'd140; cactus3 = 12'd140;
        cactus_sync = 1'b1;
        @(posedge clk); #1;
        cactus_sync = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_score", score, 0);
        check_val("async_rst_game_over", game_over, 0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            do_scan(140, -50, -50, -50, 0, 0);
            do_scan(-50, -50, -50, -50, 0, 0);
        end
        do_scan(-50, -50, 100, -50, 0, 0);
        ignored_sync(1'b1);
        check_val("restart_sync_hit_index", hit_index, 0);
        do_scan(-50, -50, -50, -50, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
